// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Sequences one FIR output per accepted input sample. Samples go into a
//   circular delay line, coefficients into a loadable memory. Each pass clears
//   the attached MAC, streams TAPS (x, coeff) pairs, waits for the MAC tick and
//   presents the captured result for one cycle.
//
//   Optional feature macro: SEQ_TIMEOUT_EN -- WAIT-state watchdog. When defined,
//   a pass whose MAC tick has not arrived after TO_CYC WAIT cycles is abandoned
//   with a one-cycle err pulse. When undefined, WAIT waits indefinitely.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   in_sample  input sample            in_valid / in_ready  sample handshake
//   coef_we    coefficient write       coef_addr / coef_data  index and value
//   x, coeff   registered MAC operands mac_rst              registered MAC clear
//   mac_y      MAC result              mac_tick             MAC done pulse
//   y_out      captured filter output  y_valid              one-cycle result strobe
//   busy       not idle                err                  watchdog pulse

module fir_tap_sequencer #(
    parameter int unsigned TAPS   = 64,
    parameter int unsigned AW     = 6,
    parameter int unsigned DW     = 16,
    parameter int unsigned ACCW   = 32,
    parameter int unsigned TO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   in_sample,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [DW-1:0]   coef_data,
    output logic [DW-1:0]   x,
    output logic [DW-1:0]   coeff,
    output logic            mac_rst,
    input  logic [ACCW-1:0] mac_y,
    input  logic            mac_tick,
    output logic [ACCW-1:0] y_out,
    output logic            y_valid,
    output logic            busy,
    output logic            err
);

    // Elaboration-time parameter sanity.
    if (TAPS != (1 << AW)) begin : g_bad_taps
        $error("TAPS must equal 2**AW");
    end
    if (TO_CYC == 0) begin : g_bad_to
        $error("TO_CYC must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StClear, StStream, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   mem_x_q [TAPS];
    logic [DW-1:0]   mem_c_q [TAPS];
    logic [AW-1:0]   wp_q, base_q;
    logic [AW-1:0]   k_q, k_d;
    logic [AW-1:0]   rd_tap, rd_addr;
    logic [DW-1:0]   x_q, x_d, coeff_q, coeff_d;
    logic            mac_rst_q, mac_rst_d;
    logic [ACCW-1:0] y_q, y_d;
    logic            accept, coef_wr, last_tap, timeout;

    assign accept   = in_valid && (state_q == StIdle);
    assign coef_wr  = coef_we && (state_q == StIdle);
    // k_q is the tap currently on the outputs; last tap issued means go to WAIT.
    assign last_tap = (k_q == AW'(TAPS - 1));
    // Tap to issue at the coming edge: tap 0 leaving CLEAR, k+1 inside STREAM.
    assign rd_tap   = (state_q == StClear) ? '0 : k_q + AW'(1);
    // Unsigned AW-bit subtraction wraps the delay-line address modulo TAPS.
    assign rd_addr  = base_q - rd_tap;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(TO_CYC + 1);
    logic [WCW-1:0] wcnt_q;

    // Held at zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt_q <= '0;
        end else if (state_q != StWait) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_q + WCW'(1);
        end
    end

    // A tick in the final WAIT cycle still wins over the watchdog.
    assign timeout = (state_q == StWait) && !mac_tick && (wcnt_q == WCW'(TO_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        coeff_d   = coeff_q;
        mac_rst_d = mac_rst_q;
        y_d       = y_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StClear;
                    mac_rst_d = 1'b1;
                    x_d       = '0;
                    coeff_d   = '0;
                    k_d       = '0;
                end
            end
            StClear: begin
                state_d   = StStream;
                mac_rst_d = 1'b0;
                x_d       = mem_x_q[rd_addr];
                coeff_d   = mem_c_q[rd_tap];
                k_d       = '0;
            end
            StStream: begin
                if (last_tap) begin
                    state_d = StWait;
                    x_d     = '0;
                    coeff_d = '0;
                end else begin
                    x_d     = mem_x_q[rd_addr];
                    coeff_d = mem_c_q[rd_tap];
                    k_d     = rd_tap;
                end
            end
            StWait: begin
                if (mac_tick) begin
                    y_d     = mac_y;
                    state_d = StDone;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            x_q       <= '0;
            coeff_q   <= '0;
            mac_rst_q <= 1'b1;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            x_q       <= x_d;
            coeff_q   <= coeff_d;
            mac_rst_q <= mac_rst_d;
            y_q       <= y_d;
        end
    end

    // Delay line and write pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q   <= '0;
            base_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                mem_x_q[i] <= '0;
            end
        end else if (accept) begin
            mem_x_q[wp_q] <= in_sample;
            base_q        <= wp_q;
            wp_q          <= wp_q + AW'(1);
        end
    end

    // Coefficient memory; writes only land while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_c_q[i] <= '0;
            end
        end else if (coef_wr) begin
            mem_c_q[coef_addr] <= coef_data;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign y_valid  = (state_q == StDone);
    assign x        = x_q;
    assign coeff    = coeff_q;
    assign mac_rst  = mac_rst_q;
    assign y_out    = y_q;
    assign err      = timeout;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: MAC model attached, expected outputs from a
// sample-history / coefficient-array reference model and from fixed tables.
module tb_fir_tap_sequencer;

    localparam int TAPS   = 64;
    localparam int AW     = 6;
    localparam int DW     = 16;
    localparam int ACCW   = 32;
    localparam int TO_CYC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_sample;
    logic            in_valid;
    logic            in_ready;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [DW-1:0]   coef_data;
    logic [DW-1:0]   x;
    logic [DW-1:0]   coeff;
    logic            mac_rst;
    logic [ACCW-1:0] mac_y;
    logic            mac_tick;
    logic [ACCW-1:0] y_out;
    logic            y_valid;
    logic            busy;
    logic            err;

    fir_tap_sequencer #(
        .TAPS  (TAPS),
        .AW    (AW),
        .DW    (DW),
        .ACCW  (ACCW),
        .TO_CYC(TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_sample(in_sample),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .x        (x),
        .coeff    (coeff),
        .mac_rst  (mac_rst),
        .mac_y    (mac_y),
        .mac_tick (mac_tick),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // MAC model: clears on mac_rst, accumulates signed products, ticks
    // tick_dly cycles after the TAPS-th product has been accumulated.
    int acc;
    int mac_cnt;
    int tick_dly = 0;
    bit tick_en  = 1'b1;

    always @(posedge clk) begin
        if (mac_rst) begin
            acc     <= 0;
            mac_cnt <= 0;
        end else begin
            acc <= acc + ($signed(x) * $signed(coeff));
            if (mac_cnt < 4000) mac_cnt <= mac_cnt + 1;
        end
    end
    assign mac_y    = acc;
    assign mac_tick = tick_en && (mac_cnt == TAPS + tick_dly);

    // Reference model: every accepted sample since reset, and the coefficients.
    logic [DW-1:0] hist[$];
    logic [DW-1:0] coef_m[TAPS];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] tap_val(input int k);
        int idx;
        idx = hist.size() - 1 - k;
        return (idx >= 0) ? hist[idx] : '0;
    endfunction

    function automatic logic [ACCW-1:0] model_y();
        int sum;
        logic [ACCW-1:0] r;
        sum = 0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + ($signed(coef_m[k]) * $signed(tap_val(k)));
        end
        r = sum;
        return r;
    endfunction

    task automatic do_reset();
        hist.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_state", {x, coeff, mac_rst, y_valid, busy, in_ready, err, y_out},
              {16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    endtask

    task automatic load_coef(input int k, input logic [DW-1:0] v);
        coef_we   = 1'b1;
        coef_addr = AW'(k);
        coef_data = v;
        @(negedge clk);
        coef_we   = 1'b0;
        coef_m[k] = v;
    endtask

    // One full pass, starting and ending at a negedge while idle.
    task automatic run_pass(input logic [DW-1:0] s, input int dly, input bit keep,
                            input bit cw, input int cw_a, input logic [DW-1:0] cw_d,
                            input bit stream_we, output logic [ACCW-1:0] yv,
                            output logic [DW-1:0] x_first, output logic [DW-1:0] x_last);
        int cyc;
        int bad;
        int extra;
        logic [ACCW-1:0] exp_y;
        yv = '0;
        x_first = '0;
        x_last = '0;
        in_sample = s;
        in_valid  = 1'b1;
        tick_dly  = dly;
        coef_we   = cw;
        coef_addr = AW'(cw_a);
        coef_data = cw_d;
        cyc = 0;
        while (!in_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_for_accept", in_ready, 1'b1);
        if (!in_ready) begin
            in_valid = 1'b0;
            coef_we  = 1'b0;
            return;
        end
        if (cw) coef_m[cw_a] = cw_d;
        hist.push_back(s);
        exp_y = model_y();
        @(negedge clk);
        coef_we = 1'b0;
        check("clear_cycle", {mac_rst, x, coeff, in_ready, busy},
              {1'b1, 16'h0, 16'h0, 1'b0, 1'b1});
        bad = 0;
        for (int k = 0; k < TAPS; k++) begin
            coef_we   = stream_we;
            coef_addr = AW'(3);
            coef_data = 16'h7777;
            @(negedge clk);
            if (x !== tap_val(k) || coeff !== coef_m[k] || mac_rst || in_ready) bad++;
            if (k == 0) x_first = x;
            if (k == TAPS - 1) x_last = x;
        end
        coef_we = 1'b0;
        check("stream_pairs_bad", bad, 0);
        extra = 0;
        cyc = 0;
        @(negedge clk);
        while (!y_valid && cyc < 300) begin
            if (in_ready || x !== '0 || coeff !== '0) extra++;
            @(negedge clk);
            cyc++;
        end
        if (in_ready) extra++;
        check("y_valid_latency", cyc, dly + 1);
        check("y_out", y_out, exp_y);
        yv = y_out;
        @(negedge clk);
        check("idle_after_done", {in_ready, y_valid, busy}, {1'b1, 1'b0, 1'b0});
        check("wait_done_ready_low", extra, 0);
        in_valid = keep;
    endtask

    typedef struct {
        logic [DW-1:0]   sample;
        int              dly;
        logic [ACCW-1:0] exp_y;
    } vec_t;

    vec_t tbl[6];
    logic [ACCW-1:0] yv;
    logic [DW-1:0]   xf, xl;
    logic [ACCW-1:0] y_prev;
    int              cnt;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // coeff = {2, 3, 5, 0...}: y[n] = 2x[n] + 3x[n-1] + 5x[n-2]
        tbl[0] = '{16'd4, 0, 32'd8};
        tbl[1] = '{16'd1, 2, 32'd14};
        tbl[2] = '{16'd7, 0, 32'd37};
        tbl[3] = '{16'd0, 5, 32'd26};
        tbl[4] = '{16'd0, 1, 32'd35};
        tbl[5] = '{16'd0, 0, 32'd0};

        rst = 1'b0;
        in_sample = '0;
        in_valid = 1'b0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        // Table-driven short filter.
        do_reset();
        load_coef(0, 16'd2);
        load_coef(1, 16'd3);
        load_coef(2, 16'd5);
        for (int i = 0; i < 6; i++) begin
            run_pass(tbl[i].sample, tbl[i].dly, 1'b0, 1'b0, 0, '0, 1'b0, yv, xf, xl);
            check("table_y", yv, tbl[i].exp_y);
        end

        // Impulse with in_valid held high throughout.
        do_reset();
        for (int k = 0; k < TAPS; k++) load_coef(k, DW'(k + 1));
        for (int i = 0; i < 65; i++) begin
            run_pass((i == 0) ? 16'd1 : 16'd0, 0, (i != 64), 1'b0, 0, '0, 1'b0, yv, xf, xl);
            if (i == 0 || i == 31 || i == 63 || i == 64)
                check("impulse_y", yv, (i < 64) ? ACCW'(i + 1) : '0);
        end

        // Wrap-around: 70 samples with all-ones coefficients; STREAM-time
        // coefficient writes on pass 69 must not stick.
        do_reset();
        for (int k = 0; k < TAPS; k++) load_coef(k, 16'd1);
        for (int i = 1; i <= 70; i++) begin
            run_pass(DW'(i), 0, 1'b0, 1'b0, 0, '0, (i == 69), yv, xf, xl);
        end
        check("wrap_y", yv, 32'd2464);
        check("wrap_x_first", xf, 16'd70);
        check("wrap_x_last", xl, 16'd7);

        // Random samples, coefficients and tick delays; some passes write a
        // coefficient in the accept cycle.
        do_reset();
        for (int k = 0; k < TAPS; k++) load_coef(k, DW'($urandom));
        for (int i = 0; i < 12; i++) begin
            run_pass(DW'($urandom), $urandom_range(0, 4), 1'b0, (i % 3 == 0),
                     $urandom_range(0, TAPS - 1), DW'($urandom), 1'b0, yv, xf, xl);
        end

        // Reset in the middle of STREAM.
        @(negedge clk);
        in_sample = 16'd1;
        in_valid = 1'b1;
        tick_dly = 0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (31) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", {mac_rst, x, coeff, busy, y_valid}, {1'b1, 16'h0, 16'h0, 1'b0, 1'b0});
        rst = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        check("midrst_no_y_valid", cnt, 0);
        hist.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = '0;
        load_coef(0, 16'd9);
        load_coef(1, 16'd4);
        run_pass(16'd1, 0, 1'b0, 1'b0, 0, '0, 1'b0, yv, xf, xl);
        check("midrst_impulse_y", yv, 32'd9);

        // MAC that never ticks.
        y_prev = y_out;
        tick_en = 1'b0;
        in_sample = 16'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TAPS + 1) @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
        cnt = 0;
        for (int w = 1; w <= TO_CYC; w++) begin
            if (w < TO_CYC) begin
                if (err || !busy) cnt++;
                @(negedge clk);
            end
        end
        check("timeout_early_err", cnt, 0);
        check("timeout_err_pulse", {err, busy}, {1'b1, 1'b1});
        @(negedge clk);
        check("timeout_back_idle", {err, busy, in_ready, y_valid}, {1'b0, 1'b0, 1'b1, 1'b0});
        check("timeout_y_kept", y_out, y_prev);
`else
        cnt = 0;
        repeat (40) begin
            if (err || !busy || y_valid) cnt++;
            @(negedge clk);
        end
        check("no_timeout_stays_busy", cnt, 0);
        check("no_timeout_y_kept", y_out, y_prev);
`endif
        tick_en = 1'b1;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
